rca_seq_arbiter: RTL
====================

// Module: rca_seq_arbiter
// PURPOSE
//  Shares one combinational 4-bit ripple-carry adder (rca4 cell netlist) among NREQ requesters.
//  Round-robin arbitration selects a requester; an FSM then steps WIDTH-bit operands through
//  the adder one nibble per cycle, chaining carry through a register.
//  Sits between client datapaths and the single adder instance; the adder connects via rca_* ports.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  WIDTH 16   operand width in bits; multiple of 4; NNIB = WIDTH/4 nibble steps
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   NREQ         per-requester add request
//  req_ready  out  NREQ         one-hot accept pulse; at most one bit high per cycle
//  req_a      in   NREQ*WIDTH   flat operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH   flat operand B, same packing
//  req_ci     in   NREQ         carry-in per requester
//  rsp_valid  out  1            result valid, held until rsp_ready
//  rsp_ready  in   1            result consumer ready
//  rsp_id     out  $clog2(NREQ) index of requester owning the result
//  rsp_sum    out  WIDTH        sum
//  rsp_co     out  1            final carry-out
//  busy       out  1            high in RUN or DONE
//  rca_a      out  4            nibble to adder input A
//  rca_b      out  4            nibble to adder input B
//  rca_ci     out  1            adder carry-in
//  rca_s      in   4            adder sum, combinational from rca_a/rca_b/rca_ci
//  rca_co     in   1            adder carry-out
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; all outputs 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, busy, rca_*.
//  IDLE: if any req_valid, pick first set bit at or after rr_ptr (wrap modulo NREQ).
//    Assert req_ready[win] combinationally in this cycle; latch a, b, ci, win.
//    Set rr_ptr=(win+1)%NREQ; go to RUN with k=0. No req_valid: stay IDLE.
//  RUN: drive rca_a=a_q[4k+:4], rca_b=b_q[4k+:4]; rca_ci = ci_q when k=0, else carry_q.
//    Each cycle capture rca_s into sum_q[4k+:4] and rca_co into carry_q; k++.
//    After k=NNIB-1, go to DONE. rca_* are 0 outside RUN.
//  DONE: rsp_valid=1, rsp_sum=sum_q, rsp_co=carry_q, rsp_id=win; hold all stable while rsp_ready=0.
//    rsp_valid&&rsp_ready -> IDLE. No new grant in the same cycle; next grant no earlier than the next IDLE cycle.
//  Latency: accept in cycle T -> rsp_valid first high in cycle T+NNIB+1. Throughput: one op per NNIB+2 cycles.
//  req_ready is never asserted in RUN/DONE; requesters hold req_valid and operands until accepted.
//  Arithmetic: modulo 2^WIDTH sum plus carry-out; {rsp_co,rsp_sum} == a+b+ci exactly.
//  Reset mid-operation: in-flight op is dropped, no rsp_valid; rr_ptr returns to 0.
//  A requester deasserting req_valid before acceptance is legal; it is simply not granted.
// CONFIGURATION
//  Macro RCA_SEQ_OVF_EN.
//    Defined: extra output rsp_ovf (1 bit, reset 0, valid with rsp_valid) = signed two's-complement overflow,
//      computed as carry into MSB XOR carry out of MSB.
//      Requires the last nibble step to also latch the MSB carry-in (a^b^s at bit 3).
//    Undefined: no rsp_ovf port and no associated logic.
// STRUCTURE
//  Package rca_seq_pkg: NIB_W=4; state enum {S_IDLE,S_RUN,S_DONE} (2 bits);
//    function for nnib(width) used by the RTL and the bench.
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs onehot grant and its index; purely combinational.
//  Adder itself stays external; no arithmetic operators on data inside this block.
// TESTING (bench instantiates rca4 netlist on rca_* ports; NREQ=4, WIDTH=16)
//  Single req0 a=16'h00FF b=16'h0001 ci=0 -> ready pulse; 5 cycles later rsp sum=16'h0100 co=0 id=0.
//  Carry across all nibbles: a=16'hFFFF b=16'h0000 ci=1 -> sum=16'h0000 co=1.
//  All four req_valid held high -> grants in order 0,1,2,3,0; rr_ptr wraps; each rsp_id matches.
//  rsp_ready low 3 cycles in DONE -> rsp_* stable, no req_ready pulses; then accepted, return to IDLE.
//  rst asserted in RUN at k=2 -> next cycle IDLE, all outputs 0; no rsp_valid for the dropped op.
//  RCA_SEQ_OVF_EN: a=16'h7FFF b=16'h0001 -> ovf=1; a=16'hFFFF b=16'h0001 -> ovf=0 co=1.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// ============================================================================
//  Module      : rca_seq_pkg
//  Description : Shared constants, FSM state encoding and nibble-count helper
//                for the sequential ripple-carry adder arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int nnib(input int width);
        return width / NIB_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rca4.sv
// ============================================================================
//  Module      : rca4
//  Description : 4-bit ripple-carry adder cell netlist built from full-adder
//                gate equations; the shared resource behind rca_seq_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic w_c;

    always_comb begin
        w_c = ci;
        s   = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker: first set request at or
//                after ptr, wrapping modulo N; returns one-hot and index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest request overwrites.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (w_sum >= (IDX_W + 1)'(N)) begin
                w_sum = w_sum - (IDX_W + 1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rca_seq_arbiter.sv
// ============================================================================
//  Module      : rca_seq_arbiter
//  Description : Round-robin shares one external 4-bit ripple-carry adder among
//                NREQ requesters, stepping WIDTH-bit operands a nibble a cycle.
//                Optional macro RCA_SEQ_OVF_EN adds the rsp_ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_seq_arbiter
    import rca_seq_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ-1:0]           req_ci,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_co,
`ifdef RCA_SEQ_OVF_EN
    output logic                      rsp_ovf,
`endif
    output logic                      busy,
    output logic [3:0]                rca_a,
    output logic [3:0]                rca_b,
    output logic                      rca_ci,
    input  logic [3:0]                rca_s,
    input  logic                      rca_co
);

    localparam int NNIB = nnib(WIDTH);
    localparam int ID_W = $clog2(NREQ);
    localparam int K_W  = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [K_W-1:0]  C_K_LAST  = K_W'(NNIB - 1);
    localparam logic [ID_W-1:0] C_ID_LAST = ID_W'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_grant_idx;
    logic [NREQ-1:0]  w_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic             r_ci;
    logic             r_carry;
    logic [K_W-1:0]   r_k;
    logic             w_accept;
    logic             w_last;
`ifdef RCA_SEQ_OVF_EN
    logic             r_ovf;
`endif

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_a_sel  = req_a[w_grant_idx*WIDTH +: WIDTH];
    assign w_b_sel  = req_b[w_grant_idx*WIDTH +: WIDTH];
    assign w_accept = (r_state == S_IDLE) && (|req_valid);
    assign w_last   = (r_k == C_K_LAST);

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        rsp_valid    = 1'b0;
        rsp_id       = '0;
        rsp_sum      = '0;
        rsp_co       = 1'b0;
        busy         = 1'b0;
        rca_a        = '0;
        rca_b        = '0;
        rca_ci       = 1'b0;
`ifdef RCA_SEQ_OVF_EN
        rsp_ovf      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready    = w_grant;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                rca_a  = r_a[r_k*NIB_W +: NIB_W];
                rca_b  = r_b[r_k*NIB_W +: NIB_W];
                rca_ci = (r_k == '0) ? r_ci : r_carry;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_id    = r_id;
                rsp_sum   = r_sum;
                rsp_co    = r_carry;
`ifdef RCA_SEQ_OVF_EN
                rsp_ovf   = r_ovf;
`endif
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
`ifdef RCA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_a_sel;
                        r_b   <= w_b_sel;
                        r_ci  <= req_ci[w_grant_idx];
                        r_id  <= w_grant_idx;
                        r_k   <= '0;
                        r_ptr <= (w_grant_idx == C_ID_LAST) ? '0 : w_grant_idx + 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[r_k*NIB_W +: NIB_W] <= rca_s;
                    r_carry                   <= rca_co;
                    r_k                       <= r_k + 1'b1;
`ifdef RCA_SEQ_OVF_EN
                    // Carry into the MSB is recovered as a^b^s at the top bit.
                    if (w_last) begin
                        r_ovf <= rca_co ^ (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ rca_s[NIB_W-1]);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
